// File: rtl/pac_flash_writer_pkg.sv
// Shared constants for the PAC write-back path: flash command codes, default
// SD-RAM / flash addresses of the PAC image, and its size.
package pac_flash_writer_pkg;

  localparam logic [1:0] FLASH_CMD_NOP   = 2'd0;
  localparam logic [1:0] FLASH_CMD_ERASE = 2'd1;
  localparam logic [1:0] FLASH_CMD_PROG  = 2'd2;

  localparam logic [23:0] RAM_ADDR_PAC   = 24'h77_E000;
  localparam logic [23:0] FLASH_ADDR_PAC = 24'h1F_0000;
  localparam logic [23:0] PAC_COPY_SIZE  = 24'h00_2000;

  localparam int PAC_PAGE_BYTES = 256;
  localparam int PAC_OFFSET_W   = 14;

  // Base plus byte offset; any carry out of bit 23 is discarded.
  function automatic logic [23:0] pac_addr(input logic [23:0]             base,
                                           input logic [PAC_OFFSET_W-1:0] offset);
    return base + {{(24-PAC_OFFSET_W){1'b0}}, offset};
  endfunction

endpackage

// File: rtl/pac_flash_writer_watchdog.sv
// Per-operation watchdog for the PAC writer: counts cycles while running and
// flags expiry after LIMIT cycles. Only instantiated with PAC_WRITE_TIMEOUT_EN.
module pac_wr_watchdog #(
  parameter logic [23:0] LIMIT = 24'd16_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  logic [23:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && !o_expired) begin
      r_count <= r_count + 24'd1;
    end
  end

  // Asserted during the LIMIT-th running cycle.
  assign o_expired = i_run && (r_count >= LIMIT - 24'd1);

endmodule

// File: rtl/pac_flash_writer.sv
// PAC write-back: erases the PAC flash sector, then copies the image from
// SD-RAM one byte at a time in 256-byte page programs.
// Optional per-operation flash timeout: define PAC_WRITE_TIMEOUT_EN.
module pac_flash_writer
  import pac_flash_writer_pkg::*;
#(
  parameter logic [23:0] RAM_BASE       = RAM_ADDR_PAC,
  parameter logic [23:0] FLASH_BASE     = FLASH_ADDR_PAC,
  parameter int          PAC_BYTES      = int'(PAC_COPY_SIZE),
  parameter int          PAGE_BYTES     = PAC_PAGE_BYTES,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        ram_rd,
  output logic [23:0] ram_addr,
  input  logic        ram_ack,
  input  logic [7:0]  ram_rdata,
  output logic        flash_cmd_valid,
  input  logic        flash_cmd_ready,
  output logic [1:0]  flash_cmd,
  output logic [23:0] flash_addr,
  output logic        flash_wvalid,
  input  logic        flash_wready,
  output logic [7:0]  flash_wdata,
  input  logic        flash_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_ERASE, S_WAIT_ERASE, S_PROG_CMD, S_RD, S_WR, S_WAIT_PROG, S_FIN, S_ABORT
  } state_t;

  localparam logic [PAC_OFFSET_W-1:0] LAST_OFFSET = PAC_OFFSET_W'(PAC_BYTES);
  localparam logic [PAC_OFFSET_W-1:0] PAGE_MASK   = PAC_OFFSET_W'(PAGE_BYTES - 1);

  state_t                  r_state, w_next;
  logic [PAC_OFFSET_W-1:0] r_offset;
  logic [PAC_OFFSET_W-1:0] w_offset_inc;
  logic [7:0]              r_data;
  logic                    w_page_end;
  logic                    w_wd_expired;

  assign w_offset_inc = r_offset + 1'b1;
  assign w_page_end   = (w_offset_inc & PAGE_MASK) == '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_offset <= '0;
      r_data   <= '0;
    end else begin
      r_state <= w_next;
      // Clearing on start also recovers a clean offset after an aborted copy.
      if (r_state == S_IDLE && start) begin
        r_offset <= '0;
      end else if (r_state == S_WR && flash_wready) begin
        r_offset <= w_offset_inc;
      end
      if (r_state == S_RD && ram_ack) begin
        r_data <= ram_rdata;
      end
    end
  end

  // NOTE: every output and the next state get a default before the case, so
  // no path through this block can infer a latch.
  always_comb begin
    w_next          = r_state;
    busy            = 1'b0;
    done            = 1'b0;
    ram_rd          = 1'b0;
    ram_addr        = '0;
    flash_cmd_valid = 1'b0;
    flash_cmd       = FLASH_CMD_NOP;
    flash_addr      = '0;
    flash_wvalid    = 1'b0;
    flash_wdata     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ERASE;
      end
      S_ERASE: begin
        busy            = 1'b1;
        flash_cmd_valid = 1'b1;
        flash_cmd       = FLASH_CMD_ERASE;
        flash_addr      = FLASH_BASE;
        if (flash_cmd_ready) w_next = S_WAIT_ERASE;
      end
      S_WAIT_ERASE: begin
        busy = 1'b1;
        if (flash_done)        w_next = S_PROG_CMD;
        else if (w_wd_expired) w_next = S_ABORT;
      end
      S_PROG_CMD: begin
        busy            = 1'b1;
        flash_cmd_valid = 1'b1;
        flash_cmd       = FLASH_CMD_PROG;
        flash_addr      = pac_addr(FLASH_BASE, r_offset);
        if (flash_cmd_ready) w_next = S_RD;
      end
      S_RD: begin
        busy     = 1'b1;
        ram_rd   = 1'b1;
        ram_addr = pac_addr(RAM_BASE, r_offset);
        if (ram_ack) w_next = S_WR;
      end
      S_WR: begin
        busy         = 1'b1;
        flash_wvalid = 1'b1;
        flash_wdata  = r_data;
        if (flash_wready) w_next = w_page_end ? S_WAIT_PROG : S_RD;
      end
      S_WAIT_PROG: begin
        busy = 1'b1;
        if (flash_done)        w_next = (r_offset == LAST_OFFSET) ? S_FIN : S_PROG_CMD;
        else if (w_wd_expired) w_next = S_ABORT;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ABORT: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef PAC_WRITE_TIMEOUT_EN
  logic w_wd_run;
  assign w_wd_run = (r_state == S_WAIT_ERASE) || (r_state == S_WAIT_PROG);

  pac_wr_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (!w_wd_run),
    .i_run     (w_wd_run),
    .o_expired (w_wd_expired)
  );

  assign error = (r_state == S_ABORT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_wd_expired     = 1'b0;
  assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_pac_flash_writer.sv
// Scoreboard bench for pac_flash_writer: randomized SD-RAM/flash responders,
// expected flash traffic derived from the copy rules, checked by a monitor.
`timescale 1ns/1ps
module tb_pac_flash_writer;

  localparam logic [23:0] RAM_BASE   = 24'h77_E000;
  localparam logic [23:0] FLASH_BASE = 24'h1F_0000;
  localparam int          PAGE_BYTES = 256;
  localparam int          N_PAGES    = 32;
  localparam int          PAC_BYTES  = N_PAGES * PAGE_BYTES;
  localparam int          TIMEOUT    = 100;

  typedef enum logic [2:0] {EV_ERASE, EV_PROG, EV_BYTE, EV_DONE, EV_ERROR} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [23:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic        busy, done, error;
  logic        ram_rd, ram_ack;
  logic [23:0] ram_addr;
  logic [7:0]  ram_rdata;
  logic        flash_cmd_valid, flash_cmd_ready;
  logic [1:0]  flash_cmd;
  logic [23:0] flash_addr;
  logic        flash_wvalid, flash_wready;
  logic [7:0]  flash_wdata;
  logic        flash_done;

  // Environment controls and response drive registers.
  bit          bp = 1'b0;
  bit          spur = 1'b0;
  int          withhold_page = -1;
  logic [7:0]  ram_key = 8'h5A;
  logic        ram_ack_d;
  logic [7:0]  ram_rdata_d;
  logic [23:0] w_ram_off;

  ev_t         exp_q[$];
  logic [23:0] exp_ram_q[$];
  int          n_checks = 0, n_errors = 0;
  int          n_done = 0, n_error = 0, n_erase = 0, n_bytes = 0;

  always #5 clk = ~clk;

  // Zero-wait mode acknowledges reads combinationally.
  assign w_ram_off = ram_addr - RAM_BASE;
  assign ram_ack   = bp ? ram_ack_d   : ram_rd;
  assign ram_rdata = bp ? ram_rdata_d : (w_ram_off[7:0] ^ ram_key);

  pac_flash_writer #(
    .RAM_BASE       (RAM_BASE),
    .FLASH_BASE     (FLASH_BASE),
    .PAC_BYTES      (PAC_BYTES),
    .PAGE_BYTES     (PAGE_BYTES),
    .TIMEOUT_CYCLES (24'(TIMEOUT))
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .ram_rd          (ram_rd),
    .ram_addr        (ram_addr),
    .ram_ack         (ram_ack),
    .ram_rdata       (ram_rdata),
    .flash_cmd_valid (flash_cmd_valid),
    .flash_cmd_ready (flash_cmd_ready),
    .flash_cmd       (flash_cmd),
    .flash_addr      (flash_addr),
    .flash_wvalid    (flash_wvalid),
    .flash_wready    (flash_wready),
    .flash_wdata     (flash_wdata),
    .flash_done      (flash_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] kind_to_cmd(input ev_kind_t k);
    case (k)
      EV_ERASE: return 2'd1;
      EV_PROG:  return 2'd2;
      default:  return 2'd3;
    endcase
  endfunction

  // Expected traffic for one copy: one erase, then per page a program command
  // followed by its bytes; ends with done, or error when aborted after a page.
  task automatic push_copy(input logic [7:0] key, input int abort_after);
    ev_t e;
    int  idx;
    e = '{kind: EV_ERASE, addr: FLASH_BASE, data: 8'h00};
    exp_q.push_back(e);
    for (int p = 0; p < N_PAGES; p++) begin
      if (p == abort_after) begin
        e = '{kind: EV_ERROR, addr: 24'h0, data: 8'h00};
        exp_q.push_back(e);
        return;
      end
      e = '{kind: EV_PROG, addr: FLASH_BASE + 24'(p * PAGE_BYTES), data: 8'h00};
      exp_q.push_back(e);
      for (int b = 0; b < PAGE_BYTES; b++) begin
        idx = p * PAGE_BYTES + b;
        exp_ram_q.push_back(RAM_BASE + 24'(idx));
        e = '{kind: EV_BYTE, addr: 24'h0, data: 8'(idx) ^ key};
        exp_q.push_back(e);
      end
    end
    e = '{kind: EV_DONE, addr: 24'h0, data: 8'h00};
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int cyc = 0;
    while (n_done < target && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    check(name, 64'(n_done >= target), 64'd1);
  endtask

  // SD-RAM and flash-controller responders.
  initial begin : env
    int ram_wait, done_wait, page_bytes, pages_done;
    logic s_rd, s_ack, s_cv, s_cr, s_wv, s_wr;
    logic [1:0]  s_cmd;
    logic [23:0] s_addr;
    ram_wait = 0; done_wait = 0; page_bytes = 0; pages_done = 0;
    flash_cmd_ready = 1'b1; flash_wready = 1'b1; flash_done = 1'b0;
    ram_ack_d = 1'b0; ram_rdata_d = 8'h00;
    forever begin
      @(negedge clk);
      s_rd = ram_rd; s_ack = ram_ack; s_addr = ram_addr;
      s_cv = flash_cmd_valid; s_cr = flash_cmd_ready; s_cmd = flash_cmd;
      s_wv = flash_wvalid; s_wr = flash_wready;
      @(posedge clk); #1;
      flash_done = 1'b0;
      ram_ack_d  = 1'b0;
      if (!reset_n) begin
        ram_wait = 0; done_wait = 0; page_bytes = 0; pages_done = 0;
        continue;
      end
      if (s_cv && s_cr) begin
        page_bytes = 0;
        if (s_cmd == 2'd1) begin
          pages_done = 0;
          done_wait  = bp ? $urandom_range(1, 8) : 1;
        end
      end
      if (s_wv && s_wr) begin
        page_bytes++;
        if (page_bytes == PAGE_BYTES) begin
          pages_done++;
          if (pages_done != withhold_page) done_wait = bp ? $urandom_range(1, 8) : 1;
        end
      end
      if (done_wait > 0) begin
        done_wait--;
        if (done_wait == 0) flash_done = 1'b1;
      end else if (spur && ((s_rd && !s_ack) || (s_wv && !s_wr)) && ($urandom % 4 == 0)) begin
        flash_done = 1'b1;
      end
      if (bp) begin
        if (s_rd && !s_ack) begin
          if (ram_wait == 0) ram_wait = ($urandom % 4 == 0) ? $urandom_range(1, 10) : 1;
          ram_wait--;
          if (ram_wait == 0) begin
            ram_ack_d   = 1'b1;
            ram_rdata_d = 8'(s_addr - RAM_BASE) ^ ram_key;
          end
        end else if (spur && s_wv && !s_wr && ($urandom % 3 == 0)) begin
          ram_ack_d   = 1'b1;
          ram_rdata_d = 8'($urandom);
        end
        flash_cmd_ready = ($urandom % 10) >= 3;
        flash_wready    = ($urandom % 10) >= 3;
      end else begin
        flash_cmd_ready = 1'b1;
        flash_wready    = 1'b1;
      end
    end
  end

  // Monitor: handshake stability and scoreboard comparison.
  initial begin : monitor
    ev_t         e;
    logic        p_cv, p_cr, p_wv, p_wr, p_rd, p_ack, p_busy;
    logic [1:0]  p_cmd;
    logic [23:0] p_caddr, p_raddr;
    logic [7:0]  p_wdata;
    p_cv = 0; p_cr = 0; p_wv = 0; p_wr = 0; p_rd = 0; p_ack = 0; p_busy = 0;
    p_cmd = '0; p_caddr = '0; p_raddr = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p_cv = 0; p_wv = 0; p_rd = 0; p_ack = 0; p_busy = 0;
        continue;
      end
      if (p_cv && !p_cr) begin
        check("cmd_valid_held", 64'(flash_cmd_valid), 64'd1);
        check("cmd_stable", 64'({flash_cmd, flash_addr}), 64'({p_cmd, p_caddr}));
      end
      if (p_wv && !p_wr) begin
        check("wvalid_held", 64'(flash_wvalid), 64'd1);
        check("wdata_stable", 64'(flash_wdata), 64'(p_wdata));
      end
      if (p_rd && !p_ack) begin
        check("ram_rd_held", 64'(ram_rd), 64'd1);
        check("ram_addr_stable", 64'(ram_addr), 64'(p_raddr));
      end
      if (p_rd && p_ack) check("ram_rd_drop", 64'(ram_rd), 64'd0);

      if (flash_cmd_valid && flash_cmd_ready) begin
        check("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("flash_cmd_addr", 64'({flash_cmd, flash_addr}), 64'({kind_to_cmd(e.kind), e.addr}));
        end
        if (flash_cmd == 2'd1) n_erase++;
      end
      if (flash_wvalid && flash_wready) begin
        n_bytes++;
        check("byte_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("flash_byte", 64'({3'(EV_BYTE), flash_wdata}), 64'({3'(e.kind), e.data}));
        end
      end
      if (ram_rd && ram_ack) begin
        check("ram_rd_expected", 64'(exp_ram_q.size() != 0), 64'd1);
        if (exp_ram_q.size() != 0) check("ram_addr", 64'(ram_addr), 64'(exp_ram_q.pop_front()));
      end
      if (done) begin
        n_done++;
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_event", 64'(3'(e.kind)), 64'(3'(EV_DONE)));
        end
        check("busy_low_on_done", 64'(busy), 64'd0);
        check("busy_before_done", 64'(p_busy), 64'd1);
      end
      if (error) begin
        n_error++;
        check("error_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("error_event", 64'(3'(e.kind)), 64'(3'(EV_ERROR)));
        end
        check("busy_low_on_error", 64'(busy), 64'd0);
      end
      p_cv = flash_cmd_valid; p_cr = flash_cmd_ready; p_cmd = flash_cmd; p_caddr = flash_addr;
      p_wv = flash_wvalid; p_wr = flash_wready; p_wdata = flash_wdata;
      p_rd = ram_rd; p_ack = ram_ack; p_raddr = ram_addr; p_busy = busy;
    end
  end

  initial begin : global_guard
    #(2_000_000);
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin : stimulus
    int base, cyc;
    reset_n = 1'b0;
    start   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({busy, done, error, ram_rd, ram_addr, flash_cmd_valid,
                                flash_cmd, flash_addr, flash_wvalid, flash_wdata}), 64'd0);
    check("start_in_reset", 64'(busy), 64'd0);
    start = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    // Copy 1: zero-wait, start spammed while busy and on the done cycle.
    base = n_bytes;
    push_copy(8'h5A, -1);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(100, 2000)) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    check("copy1_done_seen", 64'(done), 64'd1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("start_on_done_ignored", 64'(busy), 64'd0);
    check("copy1_erases", 64'(n_erase), 64'd1);
    check("copy1_bytes", 64'(n_bytes - base), 64'(PAC_BYTES));
    check("copy1_done_count", 64'(n_done), 64'd1);
    check("copy1_drained", 64'(exp_q.size() + exp_ram_q.size()), 64'd0);

    // Copy 2: backpressure with spurious flash_done / ram_ack.
    @(posedge clk); #1;
    bp = 1'b1; spur = 1'b1; ram_key = 8'hC3;
    base = n_bytes;
    push_copy(8'hC3, -1);
    pulse_start();
    wait_done(2, 60000, "copy2_done");
    check("copy2_erases", 64'(n_erase), 64'd2);
    check("copy2_bytes", 64'(n_bytes - base), 64'(PAC_BYTES));
    check("copy2_drained", 64'(exp_q.size() + exp_ram_q.size()), 64'd0);

    // Copy 3: reset at byte 1000, then restart from scratch.
    @(posedge clk); #1;
    bp = 1'b0; spur = 1'b0; ram_key = 8'h5A;
    base = n_bytes;
    push_copy(8'h5A, -1);
    pulse_start();
    cyc = 0;
    while (n_bytes < base + 1000 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check("reached_byte_1000", 64'(n_bytes >= base + 1000), 64'd1);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("reset_mid_outputs", 64'({busy, done, error, ram_rd, ram_addr, flash_cmd_valid,
                                    flash_cmd, flash_addr, flash_wvalid, flash_wdata}), 64'd0);
    exp_q.delete();
    exp_ram_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    base = n_bytes;
    push_copy(8'h5A, -1);
    pulse_start();
    wait_done(3, 25000, "copy3_done");
    check("copy3_erases", 64'(n_erase), 64'd4);
    check("copy3_bytes", 64'(n_bytes - base), 64'(PAC_BYTES));
    check("copy3_drained", 64'(exp_q.size() + exp_ram_q.size()), 64'd0);

`ifdef PAC_WRITE_TIMEOUT_EN
    // Copy 4: flash_done withheld after page 5; watchdog must abort.
    @(posedge clk); #1;
    withhold_page = 5;
    base = n_bytes;
    push_copy(8'h5A, 5);
    pulse_start();
    cyc = 0;
    while (n_bytes < base + 5 * PAGE_BYTES && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check("reached_page5_end", 64'(n_bytes >= base + 5 * PAGE_BYTES), 64'd1);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (error === 1'b1 || cyc > 3 * TIMEOUT) break;
      cyc++;
    end
    check("timeout_latency", 64'(cyc), 64'(TIMEOUT));
    repeat (5) @(negedge clk);
    check("timeout_no_done", 64'(n_done), 64'd3);
    check("timeout_idle", 64'(busy), 64'd0);
    check("timeout_drained", 64'(exp_q.size()), 64'd0);
    check("error_count", 64'(n_error), 64'd1);
`else
    repeat (5) @(negedge clk);
    check("error_count", 64'(n_error), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
